// File: rtl/child_rr_scheduler.sv
// Round-robin scheduler sharing one exclusive resource slot among the child
// instances of the parent module. One child is granted at a time; the grant is
// held until that child reports done or the watchdog forces a release.
module child_rr_scheduler #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               timeout_pulse,
    output logic [CNT_W-1:0]   grant_count
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         ptr, ptr_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [2:0]         grant_id_nx;
    logic               busy_nx;
    logic               timeout_nx;
    logic [CNT_W-1:0]   count_nx;

    logic               found;
    logic [2:0]         winner;
    int unsigned        pos;
    logic [NUM_REQ-1:0] req_sh;
    logic [NUM_REQ-1:0] done_sh;
    logic               done_hit;

    // Pick the first requesting child at or after ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = 0;
        req_sh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            req_sh = req >> pos;
            if (!found && req_sh[0]) begin
                found  = 1'b1;
                winner = 3'(pos);
            end
        end
    end

    // Completion is only meaningful from the child that currently owns the slot.
    always_comb begin
        done_sh  = done >> grant_id;
        done_hit = done_sh[0];
    end

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        timer_nx    = timer;
        grant_nx    = grant;
        grant_id_nx = grant_id;
        busy_nx     = busy;
        timeout_nx  = 1'b0;
        count_nx    = grant_count;
        case (state)
            IDLE: begin
                if (enable && (|req)) begin
                    state_nx    = GRANT;
                    grant_nx    = NUM_REQ'(1) << winner;
                    grant_id_nx = winner;
                    busy_nx     = 1'b1;
                    timer_nx    = '0;
                    if (grant_count != '1) begin
                        count_nx = grant_count + CNT_W'(1);
                    end
                end
            end
            GRANT: begin
                if (done_hit) begin
                    state_nx = RELEASE;
                    grant_nx = '0;
                    busy_nx  = 1'b0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nx   = RELEASE;
                    grant_nx   = '0;
                    busy_nx    = 1'b0;
                    timeout_nx = 1'b1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                timer_nx = '0;
                ptr_nx   = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            timer         <= '0;
            grant         <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            grant_count   <= '0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            timer         <= timer_nx;
            grant         <= grant_nx;
            grant_id      <= grant_id_nx;
            busy          <= busy_nx;
            timeout_pulse <= timeout_nx;
            grant_count   <= count_nx;
        end
    end

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Self-checking bench for child_rr_scheduler: directed scenarios plus random
// traffic, compared every cycle against a behavioural slot-ownership model.
module tb_child_rr_scheduler;

    localparam int N    = 5;
    localparam int TO   = 15;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  grant;
    logic [2:0]    grant_id;
    logic          busy;
    logic          timeout_pulse;
    logic [CW-1:0] grant_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: who owns the slot, for how long, and who is next in line.
    int m_owner;   // -1 when nobody owns the slot
    int m_held;    // edges the owner has held the slot
    bit m_gap;     // one-cycle gap after a release
    bit m_tpulse;  // watchdog release marker
    int m_next;    // first child considered at the next arbitration
    int m_last;    // most recently granted child
    int m_count;

    child_rr_scheduler #(
        .NUM_REQ(N),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_pulse(timeout_pulse),
        .grant_count  (grant_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_held   = 0;
        m_gap    = 0;
        m_tpulse = 0;
        m_next   = 0;
        m_last   = 0;
        m_count  = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] sh;
        if (m_gap) begin
            m_gap    = 0;
            m_tpulse = 0;
            m_next   = (m_last + 1) % N;
        end else if (m_owner >= 0) begin
            m_held++;
            sh = done >> m_owner;
            if (sh[0]) begin
                m_owner = -1;
                m_gap   = 1;
            end else if (m_held == TO) begin
                m_owner  = -1;
                m_gap    = 1;
                m_tpulse = 1;
            end
        end else if (enable && req != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c  = (m_next + k) % N;
                sh = req >> c;
                if (sh[0]) begin
                    m_owner = c;
                    break;
                end
            end
            m_last = m_owner;
            m_held = 0;
            if (m_count < CMAX) m_count++;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("grant", 32'(grant), exp_grant);
        check("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_tpulse));
        check("grant_count", 32'(grant_count), 32'(m_count));
        if (m_owner >= 0) check("grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    // One clock edge: advance the model with the same inputs, check at negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        done   = '0;
        enable = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();

        // Single requester, done after 3 cycles of hold.
        do_reset();
        req = 5'b00100;
        tick();
        check("s1_grant", 32'(grant), 32'h04);
        check("s1_count", 32'(grant_count), 32'd1);
        run(2);
        done = 5'b00100;
        tick();
        check("s1_released", 32'(busy), 32'd0);
        req  = '0;
        done = '0;
        tick();
        req = 5'b11111;
        tick();
        check("s1_ptr_next", 32'(grant_id), 32'd3);

        // All requesting, one-cycle holds: rotation and 3-cycle period.
        do_reset();
        req  = 5'b11111;
        done = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            tick();
            check("s2_busy", 32'(busy), 32'd1);
            check("s2_id", 32'(grant_id), 32'(g % N));
            tick();
            tick();
        end
        check("s2_count", 32'(grant_count), 32'd6);

        // Watchdog release after exactly TO cycles.
        do_reset();
        req = 5'b00010;
        tick();
        for (int c = 1; c < TO; c++) begin
            tick();
            check("s3_hold", 32'(busy), 32'd1);
        end
        tick();
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_pulse", 32'(timeout_pulse), 32'd1);
        req = 5'b11111;
        tick();
        check("s3_pulse_clr", 32'(timeout_pulse), 32'd0);
        tick();
        check("s3_next", 32'(grant_id), 32'd2);

        // Foreign done ignored; done on the last watchdog cycle wins.
        do_reset();
        req = 5'b00010;
        tick();
        done = 5'b01000;
        run(3);
        check("s4_foreign", 32'(busy), 32'd1);
        done = '0;
        run(TO - 4);
        done = 5'b00010;
        tick();
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_nopulse", 32'(timeout_pulse), 32'd0);
        done = '0;

        // Enable gating: active grant finishes, no new grant until enabled.
        do_reset();
        req = 5'b00100;
        tick();
        enable = 1'b0;
        req    = 5'b11111;
        run(2);
        check("s5_held", 32'(grant), 32'h04);
        done = 5'b00100;
        tick();
        done = '0;
        run(5);
        check("s5_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        check("s5_id", 32'(grant_id), 32'd3);

        // Asynchronous reset while a grant is active.
        do_reset();
        req = 5'b00010;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("s6_grant", 32'(grant), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 5'b10001;
        tick();
        check("s6_id", 32'(grant_id), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req    = N'($urandom);
            done   = N'($urandom & $urandom);
            enable = ($urandom_range(0, 7) != 0);
            tick();
        end

        // Counter saturation.
        enable = 1'b1;
        req    = 5'b11111;
        done   = 5'b11111;
        run(3 * (CMAX + 8));
        check("sat_count", 32'(grant_count), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
